mic_frame_aggregator: RTL and testbench

//  Producer side of the direction_calculator input interface. Gathers one sample

---
 rtl/mic_frame_aggregator.sv | 95 +++++++++
 tb/tb_mic_frame_aggregator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mic_frame_aggregator.sv
// mic_frame_aggregator: gathers skewed per-mic samples into one frame behind a valid/ready single-entry buffer
module mic_frame_aggregator #(
    parameter int SAMPLE_WIDTH   = 32,
    parameter int NUM_PERIPH     = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic [SAMPLE_WIDTH-1:0]                  central_sample_in,
    input  logic                                     central_valid_in,
    input  logic [NUM_PERIPH-1:0][SAMPLE_WIDTH-1:0]  periph_samples_in,
    input  logic [NUM_PERIPH-1:0]                    periph_valid_in,
    output logic [SAMPLE_WIDTH-1:0]                  central_mic,
    output logic [NUM_PERIPH-1:0][SAMPLE_WIDTH-1:0]  peripheral_mics,
    output logic                                     frame_valid_out,
    input  logic                                     frame_ready_in,
    output logic                                     timeout_out,
    output logic [7:0]                               dropped_count_out
);
    localparam int NCH = NUM_PERIPH + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e                              state_q;
    logic [NCH-1:0]                      rx_mask_q;
    logic [TW-1:0]                       timer_q;
    logic [NCH-1:0][SAMPLE_WIDTH-1:0]    smp_q;
    logic [SAMPLE_WIDTH-1:0]             cen_q;
    logic [NUM_PERIPH-1:0][SAMPLE_WIDTH-1:0] per_q;
    logic                                fv_q;
    logic                                timeout_q;
    logic [7:0]                          dropped_q;

    logic [NCH-1:0]                      valid_now;
    logic [NCH-1:0][SAMPLE_WIDTH-1:0]    smp_in;
    logic [NCH-1:0][SAMPLE_WIDTH-1:0]    merged;
    logic                                complete;
    logic                                timeout_fire;
    logic                                load;
    logic                                drop;

    // Channel 0 is the central mic, channels 1..N the peripherals.
    assign valid_now = {periph_valid_in, central_valid_in};
    assign smp_in    = {periph_samples_in, central_sample_in};
    assign complete  = &(rx_mask_q | valid_now);
    assign timeout_fire = (state_q == COLLECT) && (timer_q == TW'(TIMEOUT_CYCLES - 1)) && !complete;
    assign load = complete && (!fv_q || frame_ready_in);
    assign drop = complete && fv_q && !frame_ready_in;

    for (genvar g = 0; g < NCH; g++) begin : g_merge
        assign merged[g] = valid_now[g] ? smp_in[g] : smp_q[g];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            rx_mask_q <= '0;
            timer_q   <= '0;
            smp_q     <= '0;
            cen_q     <= '0;
            per_q     <= '0;
            fv_q      <= 1'b0;
            timeout_q <= 1'b0;
            dropped_q <= '0;
        end else begin
            timeout_q <= timeout_fire;
            for (int i = 0; i < NCH; i++)
                if (valid_now[i]) smp_q[i] <= smp_in[i];
            if (complete || timeout_fire) begin
                state_q   <= IDLE;
                rx_mask_q <= '0;
                timer_q   <= '0;
            end else begin
                rx_mask_q <= rx_mask_q | valid_now;
                if (state_q == COLLECT) timer_q <= timer_q + 1'b1;
                else if (|valid_now) state_q <= COLLECT;
            end
            if (load) begin
                fv_q  <= 1'b1;
                cen_q <= merged[0];
                per_q <= merged[NCH-1:1];
            end else if (frame_ready_in) begin
                fv_q <= 1'b0;
            end
            if (drop && dropped_q != 8'hff) dropped_q <= dropped_q + 8'd1;
        end
    end

    assign central_mic       = cen_q;
    assign peripheral_mics   = per_q;
    assign frame_valid_out   = fv_q;
    assign timeout_out       = timeout_q;
    assign dropped_count_out = dropped_q;
endmodule

// File: tb/tb_mic_frame_aggregator.sv
// tb_mic_frame_aggregator: table-driven vectors plus hand sequences for timeout, saturation and reset
module tb_mic_frame_aggregator;
    typedef logic [2:0][31:0] per_t;
    typedef struct {
        logic        rs, cv;
        logic [31:0] cs;
        logic [2:0]  pv;
        per_t        ps;
        logic        rdy, cd, fv;
        logic [31:0] cen;
        per_t        per;
        logic        to;
        logic [7:0]  drp;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] central_sample_in = '0;
    logic        central_valid_in = 1'b0;
    per_t        periph_samples_in = '0;
    logic [2:0]  periph_valid_in = '0;
    logic [31:0] central_mic;
    per_t        peripheral_mics;
    logic        frame_valid_out;
    logic        frame_ready_in = 1'b0;
    logic        timeout_out;
    logic [7:0]  dropped_count_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t tbl[$];

    mic_frame_aggregator dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .central_sample_in(central_sample_in), .central_valid_in(central_valid_in),
        .periph_samples_in(periph_samples_in), .periph_valid_in(periph_valid_in),
        .central_mic(central_mic), .peripheral_mics(peripheral_mics),
        .frame_valid_out(frame_valid_out), .frame_ready_in(frame_ready_in),
        .timeout_out(timeout_out), .dropped_count_out(dropped_count_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic vec_t mk(logic rs, logic cv, logic [31:0] cs, logic [2:0] pv, per_t ps, logic rdy,
                                logic cd, logic fv, logic [31:0] cen, per_t per, logic to, logic [7:0] drp);
        vec_t v;
        v.rs = rs; v.cv = cv; v.cs = cs; v.pv = pv; v.ps = ps; v.rdy = rdy;
        v.cd = cd; v.fv = fv; v.cen = cen; v.per = per; v.to = to; v.drp = drp;
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic step(input logic rs, input logic cv, input logic [31:0] cs, input logic [2:0] pv,
                        input per_t ps, input logic rdy);
        @(negedge clk_in);
        rst_in = rs; central_valid_in = cv; central_sample_in = cs;
        periph_valid_in = pv; periph_samples_in = ps; frame_ready_in = rdy;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 32'h0, 3'b0, '0, rdy);
    endtask

    initial begin
        per_t p1, pj, p2, q1, q2, q3, q4, f1, f2;
        int to_seen;
        p1 = {32'hf000_0000, 32'h1000_0000, 32'h1000_0000};
        pj = {32'hdead_0002, 32'hdead_0001, 32'hdead_0000};
        p2 = {32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
        q1 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        q2 = {32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
        q3 = {32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
        q4 = {32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
        f1 = {32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
        f2 = {32'h8888_0002, 32'h8888_0001, 32'h8888_0000};

        tbl.push_back(mk(1,0,0,0,'0,0, 1,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 1,0,0,'0,0,0));
        // Coincident valids: frame appears next cycle and is held while not ready.
        tbl.push_back(mk(0,1,32'h0000_4000,3'b111,p1,0, 1,1,32'h0000_4000,p1,0,0));
        tbl.push_back(mk(0,0,32'hdead_beef,3'b000,pj,0, 1,1,32'h0000_4000,p1,0,0));
        tbl.push_back(mk(0,0,0,0,'0,0, 1,1,32'h0000_4000,p1,0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,0));
        // Skewed valids at t, t+3, t+5, t+9 with junk on idle lanes.
        tbl.push_back(mk(0,1,32'ha1a1_a1a1,0,'0,1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,3'b001,{32'hdead,32'hdead,32'hb0b0_0000},1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,3'b010,{32'hdead,32'hb1b1_0001,32'hdead},1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,0,3'b100,{32'hb2b2_0002,32'hbad1,32'hbad0},1,
                         1,1,32'ha1a1_a1a1,{32'hb2b2_0002,32'hb1b1_0001,32'hb0b0_0000},0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,0));
        // Central repeated: newer sample wins.
        tbl.push_back(mk(0,1,32'haaaa_aaaa,0,'0,1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,1,32'hbbbb_bbbb,0,'0,1, 0,0,0,'0,0,0));
        tbl.push_back(mk(0,0,32'hcccc_cccc,3'b111,p2,1, 1,1,32'hbbbb_bbbb,p2,0,0));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,0));
        // Full buffer drops, then back-to-back load on consume.
        tbl.push_back(mk(0,1,32'hc1,3'b111,q1,0, 1,1,32'hc1,q1,0,0));
        tbl.push_back(mk(0,1,32'hc2,3'b111,q2,0, 1,1,32'hc1,q1,0,1));
        tbl.push_back(mk(0,1,32'hc3,3'b000,'0,0, 1,1,32'hc1,q1,0,1));
        tbl.push_back(mk(0,0,0,3'b111,q3,0, 1,1,32'hc1,q1,0,2));
        tbl.push_back(mk(0,1,32'hc4,3'b111,q4,1, 1,1,32'hc4,q4,0,2));
        tbl.push_back(mk(0,0,0,0,'0,1, 0,0,0,'0,0,2));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rs, tbl[i].cv, tbl[i].cs, tbl[i].pv, tbl[i].ps, tbl[i].rdy);
            check($sformatf("row%0d_fv", i), 96'(frame_valid_out), 96'(tbl[i].fv));
            check($sformatf("row%0d_to", i), 96'(timeout_out), 96'(tbl[i].to));
            check($sformatf("row%0d_drop", i), 96'(dropped_count_out), 96'(tbl[i].drp));
            if (tbl[i].cd) begin
                check($sformatf("row%0d_cen", i), 96'(central_mic), 96'(tbl[i].cen));
                check($sformatf("row%0d_per", i), peripheral_mics, tbl[i].per);
            end
        end

        // Central only: timeout pulse 64 edges after the sampling edge.
        step(0, 1, 32'h0bad_0bad, 0, '0, 1);
        to_seen = 0;
        for (int k = 1; k < 64; k++) begin
            idle(1);
            if (timeout_out || frame_valid_out) to_seen++;
        end
        check("to_early", 96'(to_seen), 96'(0));
        idle(1);
        check("to_pulse", 96'(timeout_out), 96'(1));
        check("to_nofv", 96'(frame_valid_out), 96'(0));
        idle(1);
        check("to_end", 96'(timeout_out), 96'(0));
        step(0, 1, 32'h1234_5678, 3'b111, f1, 0);
        check("to_next_fv", 96'(frame_valid_out), 96'(1));
        check("to_next_cen", 96'(central_mic), 96'(32'h1234_5678));
        check("to_next_per", peripheral_mics, f1);
        idle(1);

        // Completion on the timeout cycle wins: frame, no pulse.
        step(0, 1, 32'h9999_0000, 0, '0, 1);
        for (int k = 1; k < 64; k++) idle(1);
        step(0, 0, 0, 3'b111, f2, 1);
        check("edge_fv", 96'(frame_valid_out), 96'(1));
        check("edge_cen", 96'(central_mic), 96'(32'h9999_0000));
        check("edge_per", peripheral_mics, f2);
        idle(1);
        check("edge_to", 96'(timeout_out), 96'(0));

        // Drop counter saturation with the held frame unchanged.
        step(0, 1, 32'h5a5a_5a5a, 3'b111, f1, 0);
        for (int k = 0; k < 260; k++) step(0, 1, 32'(k), 3'b111, f2, 0);
        check("sat_drop", 96'(dropped_count_out), 96'(255));
        check("sat_cen", 96'(central_mic), 96'(32'h5a5a_5a5a));
        check("sat_per", peripheral_mics, f1);

        // Asynchronous reset with a held frame and a partial frame in flight.
        step(0, 1, 32'h7e7e_7e7e, 3'b000, '0, 0);
        #2 rst_in = 1'b1;
        #1;
        check("rst_fv", 96'(frame_valid_out), 96'(0));
        check("rst_cen", 96'(central_mic), 96'(0));
        check("rst_per", peripheral_mics, 96'(0));
        check("rst_drop", 96'(dropped_count_out), 96'(0));
        check("rst_to", 96'(timeout_out), 96'(0));
        step(1, 0, 0, 0, '0, 0);
        idle(1);
        idle(1);
        check("rel_fv", 96'(frame_valid_out), 96'(0));
        step(0, 0, 0, 3'b111, q3, 1);
        check("rel_partial_fv", 96'(frame_valid_out), 96'(0));
        step(0, 1, 32'hfeed_f00d, 3'b000, '0, 0);
        check("rel_fv2", 96'(frame_valid_out), 96'(1));
        check("rel_cen", 96'(central_mic), 96'(32'hfeed_f00d));
        check("rel_per", peripheral_mics, q3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
